// File: rtl/ca_array_run_pkg.sv
// Shared types for the cellular-automaton run engine: edge modes, FSM states,
// the latched run configuration and the rule-table lookup.
package ca_array_run_pkg;

    localparam int unsigned CA_RULE_W    = 8;
    localparam int unsigned CA_MODE_W    = 2;
    localparam int unsigned CA_DEF_WIDTH = 32;
    localparam int unsigned CA_DEF_GEN_W = 16;

    typedef enum logic [CA_MODE_W-1:0] {
        CA_MODE_FIXED     = 2'b00,
        CA_MODE_WRAP      = 2'b01,
        CA_MODE_REFLECT   = 2'b10,
        CA_MODE_FIXED_ALT = 2'b11
    } ca_mode_e;

    typedef enum logic [1:0] {
        CA_IDLE = 2'b00,
        CA_RUN  = 2'b01,
        CA_DONE = 2'b10
    } ca_state_e;

    typedef struct packed {
        logic [CA_RULE_W-1:0] rule;
        ca_mode_e             mode;
    } ca_cfg_t;

    // Wolfram rule: neighbourhood {left, centre, right} indexes the rule byte.
    function automatic logic rule_lookup(input logic [CA_RULE_W-1:0] rule,
                                         input logic l, input logic c, input logic r);
        return rule[{l, c, r}];
    endfunction

endpackage

// File: rtl/ca_array_run_if.sv
// Host-side bus of the CA run engine: seed/controls in, row and run status out.
interface ca_array_run_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned GEN_W = 16
);
    logic [7:0]       rule;
    logic [1:0]       mode;
    logic             left;
    logic             right;
    logic [WIDTH-1:0] seed;
    logic             load;
    logic [GEN_W-1:0] gens;
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] out;
    logic [GEN_W-1:0] gen_count;
    logic             busy;
    logic             done;
    logic             stable;

    modport master (
        output rule, mode, left, right, seed, load, gens, start, abort,
        input  out, gen_count, busy, done, stable
    );

    modport slave (
        input  rule, mode, left, right, seed, load, gens, start, abort,
        output out, gen_count, busy, done, stable
    );
endinterface

// File: rtl/ca_array_run_row_next.sv
// Combinational next-generation function for one CA row under a given rule and
// edge mode; kept standalone so multi-row engines can reuse it.
module ca_array_run_row_next
    import ca_array_run_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]     i_row,
    input  logic [CA_RULE_W-1:0] i_rule,
    input  ca_mode_e             i_mode,
    input  logic                 i_left,
    input  logic                 i_right,
    output logic [WIDTH-1:0]     o_nxt
);

    logic w_lb;
    logic w_rb;

    // Boundary neighbours; both fixed encodings fall through to the pins.
    always_comb begin
        w_lb = i_left;
        w_rb = i_right;
        case (i_mode)
            CA_MODE_WRAP: begin
                w_lb = i_row[WIDTH-1];
                w_rb = i_row[0];
            end
            CA_MODE_REFLECT: begin
                w_lb = i_row[0];
                w_rb = i_row[WIDTH-1];
            end
            default: ;
        endcase
    end

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
        logic w_l;
        logic w_r;
        if (i == 0) begin : g_lo
            assign w_l = w_lb;
        end else begin : g_li
            assign w_l = i_row[i-1];
        end
        if (i == int'(WIDTH) - 1) begin : g_ro
            assign w_r = w_rb;
        end else begin : g_ri
            assign w_r = i_row[i+1];
        end
        assign o_nxt[i] = rule_lookup(i_rule, w_l, i_row[i], w_r);
    end

endmodule

// File: rtl/ca_array_run.sv
// CA run engine: row register plus a start/done controller that advances a set
// number of generations, stops early on a fixed point, and honours abort.
module ca_array_run
    import ca_array_run_pkg::*;
#(
    parameter int unsigned WIDTH = CA_DEF_WIDTH,
    parameter int unsigned GEN_W = CA_DEF_GEN_W
) (
    input  logic           clk,
    input  logic           rst_n,
    ca_array_run_if.slave  bus
);

    ca_state_e        r_state;
    ca_cfg_t          r_cfg;
    logic [GEN_W-1:0] r_target;
    logic [WIDTH-1:0] r_out;
    logic [GEN_W-1:0] r_gen_count;
    logic             r_busy;
    logic             r_done;
    logic             r_stable;

    logic [WIDTH-1:0] w_nxt;
    logic [GEN_W-1:0] w_cnt_inc;

    assign w_cnt_inc = r_gen_count + GEN_W'(1);

    ca_array_run_row_next #(.WIDTH(WIDTH)) u_row_next (
        .i_row   (r_out),
        .i_rule  (r_cfg.rule),
        .i_mode  (r_cfg.mode),
        .i_left  (bus.left),
        .i_right (bus.right),
        .o_nxt   (w_nxt)
    );

    // Controller and datapath; done is only ever high for the single DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= CA_IDLE;
            r_cfg       <= '{rule: '0, mode: CA_MODE_FIXED};
            r_target    <= '0;
            r_out       <= '0;
            r_gen_count <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_stable    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                CA_IDLE: begin
                    if (bus.load) begin
                        r_out       <= bus.seed;
                        r_gen_count <= '0;
                        r_stable    <= 1'b0;
                    end else if (bus.start) begin
                        r_gen_count <= '0;
                        r_stable    <= 1'b0;
                        if (bus.gens != '0) begin
                            r_cfg    <= '{rule: bus.rule, mode: ca_mode_e'(bus.mode)};
                            r_target <= bus.gens;
                            r_busy   <= 1'b1;
                            r_state  <= CA_RUN;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= CA_DONE;
                        end
                    end
                end
                CA_RUN: begin
                    if (bus.abort) begin
                        r_busy  <= 1'b0;
                        r_state <= CA_IDLE;
                    end else if (w_nxt == r_out) begin
                        r_stable <= 1'b1;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= CA_DONE;
                    end else begin
                        r_out       <= w_nxt;
                        r_gen_count <= w_cnt_inc;
                        if (w_cnt_inc == r_target) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= CA_DONE;
                        end
                    end
                end
                CA_DONE: r_state <= CA_IDLE;
                default: r_state <= CA_IDLE;
            endcase
        end
    end

    assign bus.out       = r_out;
    assign bus.gen_count = r_gen_count;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.stable    = r_stable;

endmodule
